// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the ID/EX elastic stage.
package pipe_pkg;
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;
   localparam int ID_EX_DATA_W = 96;
   localparam int ID_EX_CTRL_W = 40;
   localparam int CTRL_RD_LSB     = 0;
   localparam int CTRL_OPCODE_LSB = 5;
   localparam int CTRL_FUNC3_LSB  = 12;
   localparam int CTRL_FUNC7_LSB  = 15;
   localparam int CTRL_FLAGS_LSB  = 22;
   localparam int CTRL_ALU_LSB    = 30;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with valid bit; clear beats load.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic         v_o,
   output logic [W-1:0] q_o
);
   logic         v_q;
   logic [W-1:0] q_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
         q_q <= '0;
      end else if (clr_i) begin
         v_q <= 1'b0;
      end else if (ld_i) begin
         v_q <= 1'b1;
         q_q <= d_i;
      end
   end
   assign v_o = v_q;
   assign q_o = q_q;
endmodule

// File: rtl/id_ex_elastic_stage.sv
// id_ex_elastic_stage: ID/EX register with valid/ready handshake and a skid slot,
// so in_ready is a flop and never depends combinationally on out_ready.
module id_ex_elastic_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W               = ID_EX_DATA_W,
   parameter int CTRL_W               = ID_EX_CTRL_W,
   parameter bit CLEAR_CTRL_ON_BUBBLE = 1'b1,
   parameter int CNT_W                = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cycles
);
   localparam int SLOT_W = DATA_W + CTRL_W;
   logic              main_v, skid_v, in_fire, out_fire;
   logic              main_ld, main_clr, skid_ld, skid_clr;
   logic [1:0]        state;
   logic [SLOT_W-1:0] main_q, skid_q, main_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   assign state    = {skid_v, main_v};
   assign in_ready = ~skid_v;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = main_v & out_ready;
   // main refills from the skid when it holds the older entry, otherwise from the input
   assign main_d   = (state == ST_FULL) ? skid_q : {in_ctrl, in_data};
   assign main_ld  = in_fire & ((state == ST_EMPTY) | out_fire) | (state == ST_FULL) & out_fire;
   assign main_clr = flush | (state == ST_BUSY) & out_fire & ~in_fire;
   assign skid_ld  = (state == ST_BUSY) & in_fire & ~out_fire;
   assign skid_clr = flush | (state == ST_FULL) & out_fire;
   pipe_slot #(.W(SLOT_W)) u_main (
      .clk(clk), .rst(rst), .clr_i(main_clr), .ld_i(main_ld),
      .d_i(main_d), .v_o(main_v), .q_o(main_q)
   );
   pipe_slot #(.W(SLOT_W)) u_skid (
      .clk(clk), .rst(rst), .clr_i(skid_clr), .ld_i(skid_ld),
      .d_i({in_ctrl, in_data}), .v_o(skid_v), .q_o(skid_q)
   );
   assign stall_d = (main_v & ~out_ready & ~&stall_q) ? stall_q + 1'b1 : stall_q;
   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else stall_q <= stall_d;
   end
   assign out_valid    = main_v;
   assign out_data     = main_q[DATA_W-1:0];
   assign out_ctrl     = (CLEAR_CTRL_ON_BUBBLE && !main_v) ? '0 : main_q[SLOT_W-1:DATA_W];
   assign stall_cycles = stall_q;
endmodule

// File: doc/id_ex_elastic_stage.md
Name: id_ex_elastic_stage

Overview:
- Parametrised successor of the fixed ID/EX pipeline register.
- Sits between Decode and Execute and carries a generic data payload plus a control payload.
- Adds a valid/ready handshake and a two-entry skid buffer, so back-pressure from Execute does not force a combinational stall path into Decode.
- Adds flush that kills every in-flight entry, bubble sanitisation of control bits, and a saturating back-pressure cycle counter.

Parameters:
- DATA_W, 96: payload width (rs1, rs2, imm concatenated by the integrator).
- CTRL_W, 40: control payload width (rd, opcode, func3/7, mem/wb/branch flags, alu_ctrl).
- CLEAR_CTRL_ON_BUBBLE, 1: 1 forces out_ctrl to all-zero whenever out_valid=0.
- CNT_W, 16: width of the stall_cycles counter.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill all entries; synchronous.
- in_valid  in  1  Decode presents an entry.
- in_ready  out  1  stage accepts; registered, equals !skid_valid.
- in_data  in  DATA_W  payload.
- in_ctrl  in  CTRL_W  control payload.
- out_valid  out  1  entry available to Execute.
- out_ready  in  1  Execute consumes.
- out_data  out  DATA_W  main-slot payload.
- out_ctrl  out  CTRL_W  main-slot control payload; sanitised per parameter.
- stall_cycles  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Transfer events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State register, encoded from the two slot valid bits:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Transitions when rst=0 and flush=0:
  - EMPTY: in_fire -> BUSY, main<=in. Otherwise stay.
  - BUSY: in_fire & !out_fire -> FULL, skid<=in. in_fire & out_fire -> BUSY, main<=in. !in_fire & out_fire -> EMPTY. Neither -> hold.
  - FULL: in_ready=0, so no input is accepted. out_fire -> BUSY, main<=skid. Otherwise hold.
- Latency: an entry accepted into EMPTY, or into BUSY with a simultaneous out_fire, appears on out_* the next cycle. An entry parked in the skid appears one cycle after the blocking entry drains.
- Ordering: strictly FIFO. The skid entry never overtakes the main entry.
- Output stability: out_data and out_ctrl are driven only from the main slot. They stay stable while out_valid=1 and out_ready=0.
- flush=1: next state is EMPTY.
  - Any in_fire in the same cycle is discarded. Upstream treats it as killed.
  - Any out_fire in the same cycle still counts as consumed.
  - flush overrides every transition above.
- rst=1: synchronous; priority over flush. All registers clear:
  - out_valid=0, in_ready=1, out_data=0, out_ctrl=0, stall_cycles=0, both slots zero.
  - Reset mid-transfer drops both entries.
- Bubble sanitisation: with CLEAR_CTRL_ON_BUBBLE=1, out_ctrl=0 whenever out_valid=0, so a bubble carries no write-enable or mem flag. out_data is left unmasked.
- stall_cycles:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at all-ones and does not wrap.
  - Cleared only by rst; flush does not clear it.
- in_ready comes from a flop. No combinational path exists from out_ready to in_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - Localparams for state encoding (ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b11).
  - The default ID/EX CTRL_W/DATA_W constants.
  - Field-offset constants for packing rd/opcode/func3/func7/flag bits into in_ctrl.
- One sub-module: pipe_slot, a DATA_W+CTRL_W register with load, clear and valid bit. It is instantiated twice, as main and skid.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data=1..8 -> out_data=1..8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1; stall_cycles=0.
- Back-pressure: accept A=0x11, then out_ready=0 while B=0x22 is offered -> B parks in the skid and in_ready=0 next cycle. Hold 3 cycles -> stall_cycles=3. Then out_ready=1 -> out_data is 0x11, then 0x22; in_ready returns to 1 after 0x11 leaves.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; neither held entry nor offered entry ever appears on out_*.
- Simultaneous in_fire, out_fire and flush in BUSY -> the out_fire entry counts as consumed; the offered entry is discarded; state is EMPTY.
- Reset asserted for 1 cycle in FULL with stall_cycles=5 -> next cycle all outputs 0, in_ready=1, stall_cycles=0.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles stops at 15.
